if_fetch_unit: RTL and testbench

- Instruction-fetch stage feeding the instruction decoder.
- Generates the PC and issues requests to instruction memory over a req/ack handshake.
- Buffers returned words in a small FIFO and presents {instruction, PC+4} to the ID stage under valid/ready flow control.
- Accepts jump/branch redirects resolved downstream: the PC is reloaded, the FIFO is flushed and stale responses are dropped.

---
 rtl/if_fetch_unit_if.sv | 24 ++
 rtl/if_fetch_unit.sv | 116 +++++++++++
 tb/tb_if_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel, ID valid/ready
// channel and the downstream redirect strobe.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc4,
    input  imem_ack, imem_rdata, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc4,
    output imem_ack, imem_rdata, id_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC generation, single-outstanding imem requests, a small
// registered-head FIFO towards ID, and redirect handling with stale-ack drop.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  if_fetch_unit_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  state_t             state, state_n;
  logic [31:0]        pc, pc_n;
  logic [31:0]        addr_q, addr_n;
  logic               req_q, req_n;
  logic               valid_q, valid_n;
  logic [CNT_W-1:0]   count, count_n, after_pop;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
  entry_t             mem [DEPTH];
  entry_t             head, head_n, wdata;
  logic               push, pop, flush, issue_ok;

  // Next-state, FIFO bookkeeping and issue decision
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    push        = 1'b0;
    pop         = valid_q && bus.id_ready;
    flush       = 1'b0;
    wdata.instr = bus.imem_rdata;
    wdata.pc4   = pc + 32'd4;

    if (state == REQ && bus.imem_ack) begin
      push = 1'b1;
      pc_n = pc + 32'd4;
    end
    // Redirect overrides everything: flush queue and drop this cycle's data.
    if (bus.redirect_valid) begin
      flush = 1'b1;
      push  = 1'b0;
      pop   = 1'b0;
      pc_n  = {bus.redirect_pc[31:2], 2'b00};
    end

    after_pop = count - CNT_W'(pop);
    count_n   = flush ? '0 : after_pop + CNT_W'(push);
    issue_ok  = count_n < CNT_W'(DEPTH);
    rd_ptr_n  = flush ? '0 : rd_ptr + PTR_W'(pop);
    wr_ptr_n  = flush ? '0 : wr_ptr + PTR_W'(push);
    valid_n   = count_n != '0;

    head_n = head;
    if (!flush) begin
      if (after_pop != '0) head_n = mem[rd_ptr_n];
      else if (push)       head_n = wdata;
    end

    case (state)
      IDLE:    state_n = issue_ok ? REQ : IDLE;
      REQ: begin
        if (bus.imem_ack)           state_n = issue_ok ? REQ : IDLE;
        else if (bus.redirect_valid) state_n = DROP;
      end
      DROP:    if (bus.imem_ack) state_n = issue_ok ? REQ : IDLE;
      default: state_n = IDLE;
    endcase

    req_n  = state_n != IDLE;
    // An outstanding request being dropped keeps its original address.
    addr_n = (state_n == DROP) ? addr_q : pc_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      head    <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      addr_q  <= addr_n;
      req_q   <= req_n;
      valid_q <= valid_n;
      count   <= count_n;
      rd_ptr  <= rd_ptr_n;
      wr_ptr  <= wr_ptr_n;
      head    <= head_n;
    end
  end

  // Storage array needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.id_valid  = valid_q;
  assign bus.id_instr  = head.instr;
  assign bus.id_pc4    = head.pc4;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run checked
// against a transaction-level model of the expected instruction stream.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int          DEPTH    = 2;

  logic clk;
  logic rst_n;
  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  bit          mem_en     = 0;
  bit          rand_delay = 0;
  int          base_delay = 0;
  int          slow_delay = 0;
  logic [31:0] slow_addr  = 32'h1;
  int          wait_cnt   = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0040_0000: return 32'h2008_0001;
      32'h0040_0004: return 32'h2009_0002;
      32'h0040_0008: return 32'h0109_5020;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // Memory responder: decides ack for the coming edge on each falling edge
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mem_en || !bus.imem_req) begin
        bus.imem_ack = 1'b0;
        wait_cnt     = 0;
      end else if (wait_cnt >= ((bus.imem_addr == slow_addr) ? slow_delay : base_delay)) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        wait_cnt       = 0;
        if (rand_delay) base_delay = $urandom_range(0, 3);
      end else begin
        bus.imem_ack = 1'b0;
        wait_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_en = 0; rand_delay = 0; base_delay = 0; slow_delay = 0; slow_addr = 32'h1;
    bus.id_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_en = 0;
    bus.id_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    repeat (2) step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
    checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, RESET_PC); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.id_valid); end
    checks++; if (bus.id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", bus.id_instr); end
    checks++; if (bus.id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=0", bus.id_pc4); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
      errors++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC);
    end
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
      errors++; $display("FAIL req_hold got req=%b addr=%h exp req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    do_reset();
    mem_en = 1; bus.id_ready = 1'b1;
    step();
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid got=%b exp=0", bus.id_valid); end
    for (int k = 0; k < 5; k++) begin
      step();
      a = RESET_PC + 32'(4 * k);
      checks++; if (bus.id_valid !== 1'b1 || bus.id_instr !== mem_word(a) || bus.id_pc4 !== a + 32'd4) begin
        errors++;
        $display("FAIL stream_%0d got v=%b i=%h p=%h exp v=1 i=%h p=%h", k, bus.id_valid, bus.id_instr, bus.id_pc4, mem_word(a), a + 32'd4);
      end
    end
  endtask

  task automatic test_stall();
    int got;
    logic [31:0] a;
    do_reset();
    mem_en = 1; bus.id_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.id_valid !== 1'b1 || bus.id_instr !== 32'h2008_0001) begin
        errors++; $display("FAIL stall_hold_%0d got v=%b i=%h exp v=1 i=20080001", i, bus.id_valid, bus.id_instr);
      end
      if (i >= 1) begin
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_%0d got=%b exp=0", i, bus.imem_req); end
      end
    end
    bus.id_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
      if (bus.id_valid === 1'b1) begin
        a = RESET_PC + 32'(4 * got);
        checks++; if (bus.id_instr !== mem_word(a) || bus.id_pc4 !== a + 32'd4) begin
          errors++; $display("FAIL stall_resume_%0d got i=%h p=%h exp i=%h p=%h", got, bus.id_instr, bus.id_pc4, mem_word(a), a + 32'd4);
        end
        got++;
      end
      step();
    end
    checks++; if (got != 6) begin errors++; $display("FAIL stall_resume_count got=%0d exp=6", got); end
  endtask

  task automatic test_redirect_late();
    bit acked;
    do_reset();
    mem_en = 1; slow_addr = 32'h0040_0008; slow_delay = 3; bus.id_ready = 1'b1;
    repeat (3) step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0008) begin
      errors++; $display("FAIL late_pre got req=%b addr=%h exp req=1 addr=00400008", bus.imem_req, bus.imem_addr);
    end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0040_0103;
    step();
    bus.redirect_valid = 1'b0;
    acked = 0;
    for (int n = 0; n < 10 && !acked; n++) begin
      checks++; if (bus.id_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0008) begin
        errors++; $display("FAIL late_hold_%0d got v=%b req=%b addr=%h exp v=0 req=1 addr=00400008", n, bus.id_valid, bus.imem_req, bus.imem_addr);
      end
      if (bus.imem_ack === 1'b1) acked = 1;
      else step();
    end
    checks++; if (!acked) begin errors++; $display("FAIL late_ack_timeout got=none exp=ack"); end
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0100 || bus.id_valid !== 1'b0) begin
      errors++; $display("FAIL late_newreq got req=%b addr=%h v=%b exp req=1 addr=00400100 v=0", bus.imem_req, bus.imem_addr, bus.id_valid);
    end
    step();
    checks++; if (bus.id_valid !== 1'b1 || bus.id_instr !== mem_word(32'h0040_0100) || bus.id_pc4 !== 32'h0040_0104) begin
      errors++; $display("FAIL late_data got v=%b i=%h p=%h exp v=1 i=%h p=00400104", bus.id_valid, bus.id_instr, bus.id_pc4, mem_word(32'h0040_0100));
    end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    mem_en = 1; bus.id_ready = 1'b1;
    repeat (2) step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0040_0200;
    step();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.id_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0200) begin
      errors++; $display("FAIL coinc_flush got v=%b req=%b addr=%h exp v=0 req=1 addr=00400200", bus.id_valid, bus.imem_req, bus.imem_addr);
    end
    step();
    checks++; if (bus.id_valid !== 1'b1 || bus.id_instr !== mem_word(32'h0040_0200) || bus.id_pc4 !== 32'h0040_0204) begin
      errors++; $display("FAIL coinc_first got v=%b i=%h p=%h exp v=1 i=%h p=00400204", bus.id_valid, bus.id_instr, bus.id_pc4, mem_word(32'h0040_0200));
    end
    step();
    checks++; if (bus.id_valid !== 1'b1 || bus.id_instr !== mem_word(32'h0040_0204) || bus.id_pc4 !== 32'h0040_0208) begin
      errors++; $display("FAIL coinc_second got v=%b i=%h p=%h exp v=1 i=%h p=00400208", bus.id_valid, bus.id_instr, bus.id_pc4, mem_word(32'h0040_0204));
    end
  endtask

  task automatic test_wrap_async_reset();
    do_reset();
    mem_en = 1; bus.id_ready = 1'b1;
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
    step();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_target got req=%b addr=%h exp req=1 addr=fffffffc", bus.imem_req, bus.imem_addr);
    end
    step();
    checks++; if (bus.imem_addr !== 32'h0 || bus.id_valid !== 1'b1 || bus.id_instr !== mem_word(32'hFFFF_FFFC) || bus.id_pc4 !== 32'h0) begin
      errors++; $display("FAIL wrap_next got addr=%h v=%b i=%h p=%h exp addr=0 v=1 i=%h p=0", bus.imem_addr, bus.id_valid, bus.id_instr, bus.id_pc4, mem_word(32'hFFFF_FFFC));
    end
    mem_en = 0;
    step();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL async_pre_req got=%b exp=1", bus.imem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== RESET_PC || bus.id_valid !== 1'b0 || bus.id_instr !== 32'h0 || bus.id_pc4 !== 32'h0) begin
      errors++; $display("FAIL async_reset got req=%b addr=%h v=%b i=%h p=%h exp req=0 addr=%h v=0 i=0 p=0", bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_instr, bus.id_pc4, RESET_PC);
    end
    step();
    rst_n = 1'b1;
  endtask

  // Model: ID must see a gap-free +4 stream from the last redirect target;
  // non-stale acks must fetch the next sequential address.
  task automatic test_random();
    int          occ, pops;
    bit          stale, prev_req, prev_ack, req, ack, redir, hs;
    logic [31:0] exp_id, exp_fetch, prev_addr, addr, tgt;
    do_reset();
    mem_en = 1; rand_delay = 1;
    occ = 0; pops = 0; stale = 0; prev_req = 0; prev_ack = 0; prev_addr = '0;
    exp_id = RESET_PC; exp_fetch = RESET_PC;
    for (int cyc = 0; cyc < 800; cyc++) begin
      step();
      req  = bus.imem_req;
      ack  = bus.imem_ack && req;
      addr = bus.imem_addr;
      checks++; if (bus.id_valid !== (occ != 0)) begin
        errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bus.id_valid, occ != 0);
      end
      if (prev_req && !prev_ack) begin
        checks++; if (req !== 1'b1 || addr !== prev_addr) begin
          errors++; $display("FAIL rnd_req_hold cyc=%0d got req=%b addr=%h exp req=1 addr=%h", cyc, req, addr, prev_addr);
        end
      end
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      redir              = ($urandom_range(0, 15) == 0);
      tgt                = $urandom;
      bus.redirect_valid = redir;
      bus.redirect_pc    = tgt;
      hs = bus.id_valid && bus.id_ready;
      if (redir) begin
        if (req && !ack) stale = 1;
        else if (ack)    stale = 0;
        occ = 0;
        exp_id = {tgt[31:2], 2'b00};
        exp_fetch = exp_id;
      end else begin
        if (hs) begin
          checks++; if (bus.id_instr !== mem_word(exp_id) || bus.id_pc4 !== exp_id + 32'd4) begin
            errors++; $display("FAIL rnd_data cyc=%0d got i=%h p=%h exp i=%h p=%h", cyc, bus.id_instr, bus.id_pc4, mem_word(exp_id), exp_id + 32'd4);
          end
          exp_id = exp_id + 32'd4;
          occ--;
          pops++;
        end
        if (ack) begin
          if (stale) stale = 0;
          else begin
            checks++; if (addr !== exp_fetch) begin
              errors++; $display("FAIL rnd_fetch_addr cyc=%0d got=%h exp=%h", cyc, addr, exp_fetch);
            end
            exp_fetch = exp_fetch + 32'd4;
            occ++;
          end
        end
        checks++; if (occ > DEPTH) begin errors++; $display("FAIL rnd_occupancy cyc=%0d got=%0d exp<=%0d", cyc, occ, DEPTH); end
      end
      prev_req = req; prev_ack = ack; prev_addr = addr;
    end
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b0;
    checks++; if (pops < 40) begin errors++; $display("FAIL rnd_progress got=%0d exp>=40", pops); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.id_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_late();
    test_redirect_ack();
    test_wrap_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
